// File: rtl/mouse_input_scheduler_if.sv
// Bundle of the mouse-side inputs and the two valid/ready channels toward the game logic.
// The master modport is the scheduler itself; the slave modport is the mouse/game side.
interface mouse_input_scheduler_if;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        left;
    logic        frame_tick;
    logic        pos_valid;
    logic [11:0] pos_x;
    logic [11:0] pos_y;
    logic        pos_ready;
    logic        evt_valid;
    logic [11:0] evt_x;
    logic [11:0] evt_y;
    logic        evt_ready;
    logic        evt_overflow;
    logic [7:0]  missed_frames;

    modport master (
        input  xpos, ypos, left, frame_tick, pos_ready, evt_ready,
        output pos_valid, pos_x, pos_y, evt_valid, evt_x, evt_y, evt_overflow, missed_frames
    );

    modport slave (
        output xpos, ypos, left, frame_tick, pos_ready, evt_ready,
        input  pos_valid, pos_x, pos_y, evt_valid, evt_x, evt_y, evt_overflow, missed_frames
    );
endinterface

// File: rtl/mouse_input_scheduler.sv
// Per-frame clamped cursor offer plus a debounced left-click event FIFO, both on
// independent valid/ready channels.
module mouse_input_scheduler #(
    parameter int H_MAX      = 799,
    parameter int V_MAX      = 599,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic                     clk,
    input logic                     rst,
    mouse_input_scheduler_if.master sched
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [11:0] H_LIM = 12'(H_MAX);
    localparam logic [11:0] V_LIM = 12'(V_MAX);

    typedef enum logic {IDLE, OFFER} state_t;

    function automatic logic [11:0] clamp(input logic [11:0] v, input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    logic [11:0] cx, cy;
    assign cx = clamp(sched.xpos, H_LIM);
    assign cy = clamp(sched.ypos, V_LIM);

    // Position channel
    state_t      state;
    logic        pos_valid;
    logic [11:0] pos_x, pos_y;
    logic [7:0]  missed_frames;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pos_valid     <= 1'b0;
            pos_x         <= '0;
            pos_y         <= '0;
            missed_frames <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sched.frame_tick) begin
                        state     <= OFFER;
                        pos_valid <= 1'b1;
                        pos_x     <= cx;
                        pos_y     <= cy;
                    end
                end
                OFFER: begin
                    // A tick that lands on the handshake cycle is still a dropped frame.
                    if (sched.frame_tick && missed_frames != 8'hFF)
                        missed_frames <= missed_frames + 8'd1;
                    if (sched.pos_ready) begin
                        state     <= IDLE;
                        pos_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pos_valid <= 1'b0;
                end
            endcase
        end
    end

    // Debounce
    logic             stable_left;
    logic [CNT_W-1:0] deb_cnt;
    logic             toggle, press;

    assign toggle = (sched.left != stable_left) && (deb_cnt == CNT_W'(DEBOUNCE - 1));
    assign press  = toggle && sched.left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_left <= 1'b0;
            deb_cnt     <= '0;
        end else if (sched.left == stable_left) begin
            deb_cnt <= '0;
        end else if (toggle) begin
            stable_left <= sched.left;
            deb_cnt     <= '0;
        end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
        end
    end

    // Click event FIFO
    logic [11:0]      mem_x [FIFO_DEPTH];
    logic [11:0]      mem_y [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, pop, do_push, overflow;

    assign full    = (count == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop     = (count != '0) && sched.evt_ready;
    assign do_push = press && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_x[wr_ptr] <= cx;
            mem_y[wr_ptr] <= cy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (press && full && !pop) overflow <= 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign sched.pos_valid     = pos_valid;
    assign sched.pos_x         = pos_x;
    assign sched.pos_y         = pos_y;
    assign sched.missed_frames = missed_frames;
    assign sched.evt_valid     = (count != '0);
    assign sched.evt_x         = (count != '0) ? mem_x[rd_ptr] : '0;
    assign sched.evt_y         = (count != '0) ? mem_y[rd_ptr] : '0;
    assign sched.evt_overflow  = overflow;
endmodule

// File: tb/tb_mouse_input_scheduler.sv
// Randomized and directed bench for mouse_input_scheduler against a queue-based reference model.
module tb_mouse_input_scheduler;
    localparam int H_MAX = 799;
    localparam int V_MAX = 599;
    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mouse_input_scheduler_if bus ();

    mouse_input_scheduler #(
        .H_MAX(H_MAX), .V_MAX(V_MAX), .DEBOUNCE(DEB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sched(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model state
    bit m_offer;
    int m_px, m_py, m_missed;
    bit m_stable;
    int m_run;
    int m_qx[$];
    int m_qy[$];
    bit m_ovf;

    function automatic void model_reset();
        m_offer = 0; m_px = 0; m_py = 0; m_missed = 0;
        m_stable = 0; m_run = 0; m_ovf = 0;
        m_qx.delete(); m_qy.delete();
    endfunction

    function automatic void model_step();
        int cx, cy;
        bit press;
        cx = (int'(bus.xpos) > H_MAX) ? H_MAX : int'(bus.xpos);
        cy = (int'(bus.ypos) > V_MAX) ? V_MAX : int'(bus.ypos);
        if (!m_offer) begin
            if (bus.frame_tick) begin
                m_offer = 1; m_px = cx; m_py = cy;
            end
        end else begin
            if (bus.frame_tick && m_missed < 255) m_missed++;
            if (bus.pos_ready) m_offer = 0;
        end
        press = 0;
        if (bus.left == m_stable) m_run = 0;
        else begin
            m_run++;
            if (m_run == DEB) begin
                m_stable = bus.left; m_run = 0; press = bus.left;
            end
        end
        if (m_qx.size() > 0 && bus.evt_ready) begin
            void'(m_qx.pop_front()); void'(m_qy.pop_front());
        end
        if (press) begin
            if (m_qx.size() < DEPTH) begin
                m_qx.push_back(cx); m_qy.push_back(cy);
            end else m_ovf = 1;
        end
    endfunction

    task automatic compare_all();
        check_eq("pos_valid", bus.pos_valid, m_offer);
        check_eq("pos_x", bus.pos_x, m_px);
        check_eq("pos_y", bus.pos_y, m_py);
        check_eq("missed_frames", bus.missed_frames, m_missed);
        check_eq("evt_valid", bus.evt_valid, m_qx.size() > 0);
        check_eq("evt_overflow", bus.evt_overflow, m_ovf);
        if (m_qx.size() > 0) begin
            check_eq("evt_x", bus.evt_x, m_qx[0]);
            check_eq("evt_y", bus.evt_y, m_qy[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic click(input int x, input int y);
        bus.xpos = 12'(x); bus.ypos = 12'(y);
        bus.left = 1'b1;
        repeat (DEB) step();
        bus.left = 1'b0;
        repeat (DEB) step();
    endtask

    task automatic sync_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.xpos = '0; bus.ypos = '0; bus.left = 1'b0; bus.frame_tick = 1'b0;
        bus.pos_ready = 1'b0; bus.evt_ready = 1'b0;
        model_reset();
        repeat (2) step();
        check_eq("rst_pos_valid", bus.pos_valid, 0);
        check_eq("rst_evt_valid", bus.evt_valid, 0);
        check_eq("rst_missed", bus.missed_frames, 0);
        rst = 1'b0;

        // Clamped x, handshake immediately accepted
        bus.xpos = 12'd900; bus.ypos = 12'd100; bus.frame_tick = 1'b1; bus.pos_ready = 1'b1;
        step();
        bus.frame_tick = 1'b0;
        check_eq("t1_valid", bus.pos_valid, 1);
        check_eq("t1_x", bus.pos_x, 799);
        check_eq("t1_y", bus.pos_y, 100);
        step();
        check_eq("t1_idle", bus.pos_valid, 0);

        // Ticks dropped during offer
        bus.xpos = 12'd10; bus.ypos = 12'd700; bus.pos_ready = 1'b0; bus.frame_tick = 1'b1;
        step();
        bus.xpos = 12'd400;
        repeat (3) step();
        bus.frame_tick = 1'b0;
        check_eq("t2_x", bus.pos_x, 10);
        check_eq("t2_y", bus.pos_y, 599);
        check_eq("t2_missed", bus.missed_frames, 3);
        bus.pos_ready = 1'b1;
        step();
        check_eq("t2_idle", bus.pos_valid, 0);
        bus.pos_ready = 1'b0;

        // Debounce: short glitch then a held press
        bus.left = 1'b1; repeat (2) step();
        bus.left = 1'b0; repeat (2) step();
        check_eq("t3_glitch", bus.evt_valid, 0);
        bus.xpos = 12'd50; bus.ypos = 12'd60; bus.left = 1'b1;
        repeat (3) step();
        check_eq("t3_early", bus.evt_valid, 0);
        step();
        check_eq("t3_valid", bus.evt_valid, 1);
        check_eq("t3_x", bus.evt_x, 50);
        check_eq("t3_y", bus.evt_y, 60);
        bus.left = 1'b0; repeat (DEB) step();
        bus.evt_ready = 1'b1; step(); bus.evt_ready = 1'b0;

        // Five presses into a four-entry FIFO
        for (int i = 0; i < 5; i++) click(200 + 10 * i, 300 + i);
        check_eq("t4_overflow", bus.evt_overflow, 1);
        check_eq("t4_head", bus.evt_x, 200);
        bus.evt_ready = 1'b1;
        repeat (4) step();
        bus.evt_ready = 1'b0;
        check_eq("t4_empty", bus.evt_valid, 0);

        // Push and pop together when full
        sync_reset();
        for (int i = 0; i < 4; i++) click(100 + 10 * i, 20 + i);
        bus.xpos = 12'd140; bus.ypos = 12'd24; bus.left = 1'b1;
        repeat (DEB - 1) step();
        bus.evt_ready = 1'b1;
        step();
        bus.evt_ready = 1'b0;
        check_eq("t5_overflow", bus.evt_overflow, 0);
        check_eq("t5_head", bus.evt_x, 110);
        bus.left = 1'b0;
        bus.evt_ready = 1'b1;
        repeat (4) step();
        check_eq("t5_empty", bus.evt_valid, 0);
        bus.evt_ready = 1'b0;

        // Saturation of missed_frames
        bus.frame_tick = 1'b1; bus.pos_ready = 1'b0;
        repeat (260) step();
        check_eq("sat_missed", bus.missed_frames, 255);
        bus.frame_tick = 1'b0;

        // Async reset mid-handshake with queued events
        sync_reset();
        bus.frame_tick = 1'b1; step(); step(); bus.frame_tick = 1'b0;
        click(30, 40); click(31, 41);
        check_eq("t6_pre_events", bus.evt_valid, 1);
        rst = 1'b1;
        #1;
        check_eq("t6_pos_valid", bus.pos_valid, 0);
        check_eq("t6_evt_valid", bus.evt_valid, 0);
        check_eq("t6_missed", bus.missed_frames, 0);
        step();
        rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.xpos = 12'($urandom_range(795, 805));
                bus.ypos = 12'($urandom_range(595, 605));
            end else begin
                bus.xpos = 12'($urandom_range(0, 4095));
                bus.ypos = 12'($urandom_range(0, 4095));
            end
            if ($urandom_range(0, 5) == 0) bus.left = ~bus.left;
            bus.frame_tick = ($urandom_range(0, 7) == 0);
            bus.pos_ready  = ($urandom_range(0, 2) == 0);
            bus.evt_ready  = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
